// File: rtl/fsm_switch_sequencer.sv
// Switch input conditioner and event queue for the lab switch-driven FSM.
// Four raw slide switches are synchronised, debounced and edge-detected.
// Presses that obey the one-switch-only rule are queued as one-hot events
// and handed downstream over valid/ready. A clear pulse is issued on an
// operator request (clr_in rising edge) or after an idle timeout.
module fsm_switch_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPTH           = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_in,
    input  logic       clr_in,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [3:0] ev_code,
    output logic       fsm_clr,
    output logic       err_multi,
    output logic       overflow
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TM_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [TM_W-1:0]  TIMER_LAST = TM_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        s1;
    logic [3:0]        s2;
    logic [3:0]        stable;
    logic [3:0]        stable_d;
    logic [DB_W-1:0]   db_cnt [4];
    logic [3:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [TM_W-1:0]   idle_timer;
    logic              clr_d;

    logic [3:0]        rise;
    logic              legal;
    logic              illegal;
    logic              clr_rise;
    logic              timeout;
    logic              clear_trig;
    logic              pop;
    logic              accept;

    // Two-flop synchroniser for the asynchronous switch inputs.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // Per-switch debounce: stable flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copies for rising-edge detection of the debounced switches and clr_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d <= '0;
            clr_d    <= 1'b0;
        end else begin
            stable_d <= stable;
            clr_d    <= clr_in;
        end
    end

    // Press classification, clear triggers and FIFO handshake decode.
    always_comb begin
        rise       = stable & ~stable_d;
        // A press is legal only when it is the sole switch up after the edge.
        legal      = $onehot(rise) && ((stable & ~rise) == 4'b0000);
        illegal    = (rise != 4'b0000) && !legal;
        clr_rise   = clr_in & ~clr_d;
        timeout    = (count == '0) && (idle_timer == TIMER_LAST);
        clear_trig = clr_rise | timeout;
        pop        = (state == PEND) && ev_ready;
        // A clear discards a coincident press outright; a full FIFO still takes
        // the press when the head leaves on the same edge.
        accept     = legal && !clear_trig && ((count != FULL_COUNT) || pop);
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        count_next = count;
        if (accept && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !accept) begin
            count_next = count - 1'b1;
        end
    end

    // Event storage; the head is read combinationally below.
    // NOTE: storage is deliberately not reset; entries are only visible through valid pointers/count.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= rise;
    end

    assign ev_code = ev_valid ? mem[rd_ptr] : 4'b0000;

    // Control FSM: FIFO pointers, idle timer and registered output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            idle_timer <= '0;
            ev_valid   <= 1'b0;
            fsm_clr    <= 1'b0;
            err_multi  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            err_multi <= illegal;
            overflow  <= legal && !clear_trig && !accept;
            if (clear_trig) begin
                state      <= CLEAR;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                idle_timer <= '0;
                ev_valid   <= 1'b0;
                fsm_clr    <= 1'b1;
            end else begin
                fsm_clr  <= 1'b0;
                count    <= count_next;
                ev_valid <= (count_next != '0);
                state    <= (count_next != '0) ? PEND : IDLE;
                if (accept) wr_ptr <= wr_ptr + 1'b1;
                if (pop)    rd_ptr <= rd_ptr + 1'b1;
                if (accept) begin
                    idle_timer <= '0;
                end else if (count == '0) begin
                    idle_timer <= idle_timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fsm_switch_sequencer.sv
// Directed self-checking bench for fsm_switch_sequencer. A second instance
// with a short idle timeout exercises the automatic clear.
module tb_fsm_switch_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] sw_in;
    logic       clr_in;
    logic       ev_ready;

    logic       ev_valid;
    logic [3:0] ev_code;
    logic       fsm_clr;
    logic       err_multi;
    logic       overflow;

    logic       t_ev_valid;
    logic [3:0] t_ev_code;
    logic       t_fsm_clr;
    logic       t_err_multi;
    logic       t_overflow;

    int checks = 0;
    int errors = 0;

    fsm_switch_sequencer #(
        .DEBOUNCE_CYCLES(4), .DEPTH(4), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in), .clr_in(clr_in), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_code(ev_code), .fsm_clr(fsm_clr),
        .err_multi(err_multi), .overflow(overflow)
    );

    fsm_switch_sequencer #(
        .DEBOUNCE_CYCLES(4), .DEPTH(4), .TIMEOUT_CYCLES(10)
    ) dut_to (
        .clk(clk), .reset(reset), .sw_in(sw_in), .clr_in(clr_in), .ev_ready(ev_ready),
        .ev_valid(t_ev_valid), .ev_code(t_ev_code), .fsm_clr(t_fsm_clr),
        .err_multi(t_err_multi), .overflow(t_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; sw_in = 4'b0000; clr_in = 1'b0; ev_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Press and release one code: 8 cycles down, 8 cycles up; counts pulses seen.
    task automatic press(input logic [3:0] code, output int ovf, output int err);
        ovf = 0; err = 0;
        sw_in = code;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) sw_in = 4'b0000;
            tick();
            ovf += int'(overflow);
            err += int'(err_multi);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sw_in = 4'b1111; clr_in = 1'b1; ev_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({ev_valid, ev_code, fsm_clr, err_multi, overflow, t_fsm_clr} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 000000000",
                     {ev_valid, ev_code, fsm_clr, err_multi, overflow, t_fsm_clr});
        end
        do_reset();
    endtask

    task automatic test_single_press();
        int bad;
        do_reset();
        sw_in = 4'b0001;
        repeat (6) tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL single_early_valid: got %b, expected 0", ev_valid);
        end
        tick();
        checks++;
        if ({ev_valid, ev_code} !== 5'b1_0001) begin
            errors++; $display("FAIL single_valid_edge7: got %b, expected 10001", {ev_valid, ev_code});
        end
        bad = 0;
        repeat (20) begin
            tick();
            if ({ev_valid, ev_code} !== 5'b1_0001) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL single_hold_stable: got %0d unstable cycles, expected 0", bad);
        end
        sw_in = 4'b0000; ev_ready = 1'b1;
        tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL single_pop: got %b, expected 0", ev_valid);
        end
        bad = 0;
        repeat (12) begin
            tick();
            if (ev_valid !== 1'b0 || err_multi !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL single_release_quiet: got %0d active cycles, expected 0", bad);
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_glitch_and_multi();
        int bad;
        do_reset();
        sw_in = 4'b0001;
        repeat (3) tick();
        sw_in = 4'b0000;
        bad = 0;
        repeat (12) begin
            tick();
            if (ev_valid !== 1'b0 || err_multi !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL glitch_no_event: got %0d active cycles, expected 0", bad);
        end
        sw_in = 4'b0011;
        repeat (6) tick();
        checks++;
        if (err_multi !== 1'b0) begin
            errors++; $display("FAIL multi_early: got %b, expected 0", err_multi);
        end
        tick();
        checks++;
        if ({err_multi, ev_valid} !== 2'b10) begin
            errors++; $display("FAIL multi_pulse: got %b, expected 10", {err_multi, ev_valid});
        end
        tick();
        checks++;
        if (err_multi !== 1'b0) begin
            errors++; $display("FAIL multi_single_cycle: got %b, expected 0", err_multi);
        end
        bad = 0;
        repeat (10) begin
            tick();
            if (ev_valid !== 1'b0 || err_multi !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL multi_fifo_empty: got %0d active cycles, expected 0", bad);
        end
        sw_in = 4'b0000;
        repeat (8) tick();
    endtask

    task automatic test_held_plus_press();
        do_reset();
        ev_ready = 1'b1;
        sw_in = 4'b0100;
        repeat (7) tick();
        checks++;
        if ({ev_valid, ev_code} !== 5'b1_0100) begin
            errors++; $display("FAIL held_sw3_event: got %b, expected 10100", {ev_valid, ev_code});
        end
        repeat (5) tick();
        sw_in = 4'b0101;
        repeat (7) tick();
        checks++;
        if ({err_multi, ev_valid} !== 2'b10) begin
            errors++; $display("FAIL held_add_sw1_err: got %b, expected 10", {err_multi, ev_valid});
        end
        tick();
        checks++;
        if ({err_multi, ev_valid} !== 2'b00) begin
            errors++; $display("FAIL held_add_sw1_once: got %b, expected 00", {err_multi, ev_valid});
        end
        sw_in = 4'b0000; ev_ready = 1'b0;
        repeat (10) tick();
        sw_in = 4'b0001;
        repeat (7) tick();
        checks++;
        if ({ev_valid, ev_code, err_multi} !== 6'b1_0001_0) begin
            errors++; $display("FAIL held_then_sw1: got %b, expected 100010", {ev_valid, ev_code, err_multi});
        end
        sw_in = 4'b0000; ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_overflow();
        logic [3:0] fill [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
        int ovf, err, ovf_total, err_total;
        do_reset();
        ovf_total = 0; err_total = 0;
        for (int i = 0; i < 4; i++) begin
            press(fill[i], ovf, err);
            ovf_total += ovf; err_total += err;
        end
        checks++;
        if (ovf_total != 0 || err_total != 0) begin
            errors++; $display("FAIL ovf_fill_quiet: got ovf=%0d err=%0d, expected 0 0", ovf_total, err_total);
        end
        press(4'b0010, ovf, err);
        checks++;
        if (ovf != 1) begin
            errors++; $display("FAIL ovf_fifth_press: got %0d pulses, expected 1", ovf);
        end
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ev_valid, ev_code} !== {1'b1, fill[i]}) begin
                errors++; $display("FAIL ovf_drain_%0d: got %b, expected 1%b", i, {ev_valid, ev_code}, fill[i]);
            end
            tick();
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_drained: got %b, expected 0", ev_valid);
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_full_pop_coincide();
        logic [3:0] fill [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
        logic [3:0] rest [3] = '{4'b0100, 4'b0001, 4'b0010};
        int ovf, err;
        do_reset();
        for (int i = 0; i < 4; i++) press(fill[i], ovf, err);
        sw_in = 4'b0010;
        repeat (6) tick();
        ev_ready = 1'b1;
        tick();
        checks++;
        if ({overflow, ev_valid, ev_code} !== 6'b0_1_0010) begin
            errors++; $display("FAIL coincide_accept: got %b, expected 010010", {overflow, ev_valid, ev_code});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({overflow, ev_valid, ev_code} !== {2'b01, rest[i]}) begin
                errors++; $display("FAIL coincide_drain_%0d: got %b, expected 01%b", i, {overflow, ev_valid, ev_code}, rest[i]);
            end
        end
        tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++; $display("FAIL coincide_drained: got %b, expected 0", ev_valid);
        end
        sw_in = 4'b0000; ev_ready = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_timeout();
        logic exp;
        do_reset();
        for (int i = 1; i <= 25; i++) begin
            tick();
            exp = (i == 10) || (i == 20);
            checks++;
            if ({t_fsm_clr, t_ev_valid, t_ev_code, t_err_multi, t_overflow} !== {exp, 7'b0}) begin
                errors++;
                $display("FAIL timeout_cycle_%0d: got %b, expected %b", i,
                         {t_fsm_clr, t_ev_valid, t_ev_code, t_err_multi, t_overflow}, {exp, 7'b0});
            end
        end
    endtask

    task automatic test_clr_in();
        int ovf, err, pulses;
        do_reset();
        press(4'b0001, ovf, err);
        press(4'b0010, ovf, err);
        checks++;
        if ({ev_valid, ev_code} !== 5'b1_0001) begin
            errors++; $display("FAIL clr_queued: got %b, expected 10001", {ev_valid, ev_code});
        end
        clr_in = 1'b1;
        tick();
        checks++;
        if ({fsm_clr, ev_valid, ev_code} !== 6'b1_0_0000) begin
            errors++; $display("FAIL clr_pulse: got %b, expected 100000", {fsm_clr, ev_valid, ev_code});
        end
        pulses = 0;
        repeat (6) begin
            tick();
            pulses += int'(fsm_clr) + int'(ev_valid);
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL clr_single_cycle: got %0d active samples, expected 0", pulses);
        end
        clr_in = 1'b0;
        press(4'b0100, ovf, err);
        clr_in = 1'b1;
        tick();
        checks++;
        if (fsm_clr !== 1'b1) begin
            errors++; $display("FAIL clr_second_pulse: got %b, expected 1", fsm_clr);
        end
        #1 reset = 1'b1;
        clr_in = 1'b0;
        #1;
        checks++;
        if ({fsm_clr, ev_valid, ev_code, err_multi, overflow} !== 8'b0) begin
            errors++; $display("FAIL clr_reset_abort: got %b, expected 00000000",
                               {fsm_clr, ev_valid, ev_code, err_multi, overflow});
        end
        tick();
        reset = 1'b0;
        pulses = 0;
        repeat (5) begin
            tick();
            pulses += int'(fsm_clr);
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL clr_no_pulse_from_reset: got %0d pulses, expected 0", pulses);
        end
    endtask

    initial begin
        reset = 1'b1; sw_in = 4'b0000; clr_in = 1'b0; ev_ready = 1'b0;
        test_reset();
        test_single_press();
        test_glitch_and_multi();
        test_held_plus_press();
        test_overflow();
        test_full_pop_coincide();
        test_timeout();
        test_clr_in();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
